// File: rtl/dma_cxy_job_sched_pkg.sv
// Shared register map, control-word layout and state encodings for the DMA job scheduler.
// Pure definitions; no timing or flow control.
package dma_cxy_pkg;

  localparam logic [11:0] DMA_REG_RD   = 12'h000;
  localparam logic [11:0] DMA_REG_WR   = 12'h004;
  localparam logic [11:0] DMA_REG_LEN  = 12'h008;
  localparam logic [11:0] DMA_REG_CTRL = 12'h00C;

  localparam int CTRL_START      = 0;
  localparam int CTRL_INT_EN     = 1;
  localparam int CTRL_INT_CLR    = 2;
  localparam int CTRL_RD_INC     = 3;
  localparam int CTRL_WR_INC     = 4;
  localparam int CTRL_INT_STATUS = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECLR,
    ST_PROG,
    ST_WAIT_INT,
    ST_CLR,
    ST_WAIT_LOW,
    ST_DONE
  } sched_state_e;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_phase_e;

  typedef struct packed {
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [31:0] len;
    logic        rd_inc;
    logic        wr_inc;
  } job_t;

  // Interrupt enable is always on; the status bit is read-only and written as 0.
  function automatic logic [31:0] ctrl_word(input logic start, input logic clr,
                                            input logic rd_inc, input logic wr_inc);
    logic [31:0] w;
    w                  = '0;
    w[CTRL_START]      = start;
    w[CTRL_INT_EN]     = 1'b1;
    w[CTRL_INT_CLR]    = clr;
    w[CTRL_RD_INC]     = rd_inc;
    w[CTRL_WR_INC]     = wr_inc;
    w[CTRL_INT_STATUS] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/dma_cxy_job_sched_if.sv
// APB master bus towards the DMA register window plus the DMA interrupt line.
// Zero-wait-state APB; the scheduler never stalls on PREADY.
interface dma_cxy_job_sched_if;
  logic        M_PCLKEN;
  logic        M_PSEL;
  logic        M_PENABLE;
  logic        M_PWRITE;
  logic [11:0] M_PADDR;
  logic [31:0] M_PWDATA;
  logic        dma_int;

  modport master (
    output M_PCLKEN, M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA,
    input  dma_int
  );

  modport slave (
    input  M_PCLKEN, M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA,
    output dma_int
  );
endinterface

// File: rtl/dma_cxy_job_sched_rr_arb.sv
// Combinational round-robin pick: first valid bit at or after ptr, wrapping.
// Zero latency; caller decides when the result is consumed.
module dma_cxy_rr_arb #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [2:0]       ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [2:0]       win_idx,
  output logic             any
);

  logic found;

  always_comb begin
    found   = 1'b0;
    win_idx = 3'd0;
    win_oh  = '0;
    any     = |valid;
    // First pass covers [ptr, N_REQ), second pass the wrapped part [0, ptr).
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && valid[i] && (3'(i) >= ptr)) begin
        found   = 1'b1;
        win_idx = 3'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && valid[i]) begin
        found   = 1'b1;
        win_idx = 3'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      win_oh[i] = found && (win_idx == 3'(i));
    end
  end

endmodule

// File: rtl/dma_cxy_job_sched.sv
// Round-robin job scheduler: programs the DMA over APB, waits for its interrupt, reports done/err.
// Grant one cycle after capture; one job in flight, other requesters hold req_valid until granted.
module dma_cxy_job_sched
  import dma_cxy_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic                 FCLK,
  input  logic                 RESET,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*32-1:0]  req_rd_addr,
  input  logic [N_REQ*32-1:0]  req_wr_addr,
  input  logic [N_REQ*32-1:0]  req_len,
  input  logic [N_REQ-1:0]     req_rd_inc,
  input  logic [N_REQ-1:0]     req_wr_inc,
  output logic [N_REQ-1:0]     req_grant,
  output logic [N_REQ-1:0]     req_done,
  output logic [N_REQ-1:0]     req_err,
  output logic                 busy,
  output logic [2:0]           cur_chan,
  dma_cxy_job_sched_if.master  apb
);

  sched_state_e state_q, state_d;
  apb_phase_e   phase_q, phase_d;
  logic [1:0]   widx_q, widx_d;
  job_t         job_q, job_d, cap;
  logic [2:0]   cur_q, cur_d, ptr_q, ptr_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         err_q, err_d;
  logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d, derr_q, derr_d;

  logic [N_REQ-1:0] win_oh;
  logic [2:0]       win_idx;
  logic             arb_any;
  logic             wr_end;

  dma_cxy_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .valid   (req_valid),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (arb_any)
  );

  always_comb begin
    cap = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) begin
        cap.rd_addr = req_rd_addr[i*32 +: 32];
        cap.wr_addr = req_wr_addr[i*32 +: 32];
        cap.len     = req_len[i*32 +: 32];
        cap.rd_inc  = req_rd_inc[i];
        cap.wr_inc  = req_wr_inc[i];
      end
    end
  end

  assign wr_end = (phase_q == APB_ACCESS);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    widx_d  = widx_q;
    job_d   = job_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    grant_d = '0;
    done_d  = '0;
    derr_d  = '0;

    if (phase_q == APB_SETUP)  phase_d = APB_ACCESS;
    if (phase_q == APB_ACCESS) phase_d = APB_IDLE;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          job_d   = cap;
          cur_d   = win_idx;
          ptr_d   = (win_idx == 3'(N_REQ-1)) ? 3'd0 : win_idx + 3'd1;
          grant_d = win_oh;
          err_d   = 1'b0;
          widx_d  = 2'd0;
          if (cap.len == 32'd0) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (apb.dma_int) begin
            state_d = ST_PRECLR;
            phase_d = APB_SETUP;
          end else begin
            state_d = ST_PROG;
            phase_d = APB_SETUP;
          end
        end
      end
      // Clear write first, then hold until the stale interrupt has dropped.
      ST_PRECLR: begin
        if (phase_q == APB_IDLE && !apb.dma_int) begin
          state_d = ST_PROG;
          phase_d = APB_SETUP;
          widx_d  = 2'd0;
        end
      end
      ST_PROG: begin
        if (wr_end) begin
          if (widx_q == 2'd3) begin
            state_d = ST_WAIT_INT;
            cnt_d   = 32'd0;
          end else begin
            widx_d  = widx_q + 2'd1;
            phase_d = APB_SETUP;
          end
        end
      end
      ST_WAIT_INT: begin
        cnt_d = cnt_q + 32'd1;
        if (apb.dma_int) begin
          state_d = ST_CLR;
          phase_d = APB_SETUP;
          err_d   = 1'b0;
        end else if (TIMEOUT_CYC != 0 && cnt_d == 32'(TIMEOUT_CYC)) begin
          state_d = ST_CLR;
          phase_d = APB_SETUP;
          err_d   = 1'b1;
        end
      end
      ST_CLR: begin
        if (wr_end) state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!apb.dma_int) state_d = ST_DONE;
      end
      ST_DONE: begin
        for (int i = 0; i < N_REQ; i++) begin
          done_d[i] = (cur_q == 3'(i));
          derr_d[i] = (cur_q == 3'(i)) && err_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge FCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      phase_q <= APB_IDLE;
      widx_q  <= 2'd0;
      job_q   <= '0;
      cur_q   <= 3'd0;
      ptr_q   <= 3'd0;
      cnt_q   <= 32'd0;
      err_q   <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      derr_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      widx_q  <= widx_d;
      job_q   <= job_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      derr_q  <= derr_d;
    end
  end

  logic [11:0] paddr;
  logic [31:0] pwdata;

  always_comb begin
    paddr  = 12'h000;
    pwdata = 32'h0;
    if (phase_q != APB_IDLE) begin
      case (state_q)
        ST_PROG: begin
          case (widx_q)
            2'd0:    begin paddr = DMA_REG_RD;   pwdata = job_q.rd_addr; end
            2'd1:    begin paddr = DMA_REG_WR;   pwdata = job_q.wr_addr; end
            2'd2:    begin paddr = DMA_REG_LEN;  pwdata = job_q.len;     end
            default: begin paddr = DMA_REG_CTRL;
                           pwdata = ctrl_word(1'b1, 1'b0, job_q.rd_inc, job_q.wr_inc); end
          endcase
        end
        ST_PRECLR, ST_CLR: begin
          paddr  = DMA_REG_CTRL;
          pwdata = ctrl_word(1'b0, 1'b1, job_q.rd_inc, job_q.wr_inc);
        end
        default: ;
      endcase
    end
  end

  assign apb.M_PCLKEN  = 1'b1;
  assign apb.M_PSEL    = (phase_q != APB_IDLE);
  assign apb.M_PENABLE = (phase_q == APB_ACCESS);
  assign apb.M_PWRITE  = (phase_q != APB_IDLE);
  assign apb.M_PADDR   = paddr;
  assign apb.M_PWDATA  = pwdata;

  assign req_grant = grant_q;
  assign req_done  = done_q;
  assign req_err   = derr_q;
  assign busy      = (state_q != ST_IDLE);
  assign cur_chan  = cur_q;

endmodule

// File: tb/tb_dma_cxy_job_sched.sv
// Directed bench for the DMA job scheduler with a small DMA interrupt model and APB/event logger.
module tb_dma_cxy_job_sched;

  logic         FCLK;
  logic         RESET;
  logic [3:0]   req_valid;
  logic [127:0] req_rd_addr, req_wr_addr, req_len;
  logic [3:0]   req_rd_inc, req_wr_inc;
  logic [3:0]   req_grant, req_done, req_err;
  logic         busy;
  logic [2:0]   cur_chan;

  logic model_int, stale_int;
  int   int_delay, int_cnt, cyc;
  int   n_chk, n_err;
  int   psel_cnt;
  int   wa[$], wd[$], wc[$];
  int   g_idx[$], g_cyc[$], d_idx[$], d_err[$], d_cyc[$];

  dma_cxy_job_sched_if apb();
  assign apb.dma_int = model_int | stale_int;

  dma_cxy_job_sched #(.N_REQ(4), .TIMEOUT_CYC(100)) dut (
    .FCLK        (FCLK),
    .RESET       (RESET),
    .req_valid   (req_valid),
    .req_rd_addr (req_rd_addr),
    .req_wr_addr (req_wr_addr),
    .req_len     (req_len),
    .req_rd_inc  (req_rd_inc),
    .req_wr_inc  (req_wr_inc),
    .req_grant   (req_grant),
    .req_done    (req_done),
    .req_err     (req_err),
    .busy        (busy),
    .cur_chan    (cur_chan),
    .apb         (apb.master)
  );

  initial FCLK = 1'b0;
  always #5 FCLK = ~FCLK;

  initial cyc = 0;
  always @(posedge FCLK) cyc++;

  // DMA model: start write arms a countdown, clear write drops the interrupt.
  initial begin model_int = 1'b0; int_cnt = 0; end
  always @(negedge FCLK) begin
    if (RESET) begin
      model_int = 1'b0;
      int_cnt   = 0;
    end else if (apb.M_PSEL && apb.M_PENABLE && apb.M_PADDR == 12'h00C) begin
      if (apb.M_PWDATA[2]) model_int = 1'b0;
      if (apb.M_PWDATA[0] && int_delay != 0) int_cnt = int_delay;
    end else if (int_cnt > 0) begin
      int_cnt--;
      if (int_cnt == 0) model_int = 1'b1;
    end
  end

  initial psel_cnt = 0;
  always @(negedge FCLK) begin
    if (!RESET) begin
      if (apb.M_PSEL) psel_cnt++;
      if (apb.M_PSEL && apb.M_PENABLE) begin
        wa.push_back(int'(apb.M_PADDR));
        wd.push_back(int'(apb.M_PWDATA));
        wc.push_back(cyc);
      end
      for (int i = 0; i < 4; i++) begin
        if (req_grant[i]) begin g_idx.push_back(i); g_cyc.push_back(cyc); end
        if (req_done[i]) begin d_idx.push_back(i); d_err.push_back(int'(req_err[i])); d_cyc.push_back(cyc); end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge FCLK);
    #1;
  endtask

  task automatic do_reset;
    RESET     = 1'b1;
    req_valid = '0;
    stale_int = 1'b0;
    repeat (2) tick;
    RESET = 1'b0;
    tick;
  endtask

  task automatic set_job(input int i, input logic [31:0] rd, input logic [31:0] wr,
                         input logic [31:0] len, input logic ri, input logic wi);
    req_rd_addr[i*32 +: 32] = rd;
    req_wr_addr[i*32 +: 32] = wr;
    req_len[i*32 +: 32]     = len;
    req_rd_inc[i]           = ri;
    req_wr_inc[i]           = wi;
  endtask

  // Raise one request, drop it on grant, return after its done pulse.
  task automatic run_one(input int i, input int budget, input int wr_mark);
    bit seen;
    seen = 1'b0;
    req_valid[i] = 1'b1;
    for (int k = 0; k < budget && !seen; k++) begin
      tick;
      if (req_grant[i]) req_valid[i] = 1'b0;
      if (stale_int && wa.size() > wr_mark) stale_int = 1'b0;
      if (req_done[i]) seen = 1'b1;
    end
    req_valid[i] = 1'b0;
    chk("job_done_seen", 32'(seen), 32'd1);
    tick;
  endtask

  // Hold a request set, drop bits on grant (optionally re-raise on done) until n grants.
  task automatic rr_run(input logic [3:0] start, input bit reassert, input int n);
    int got;
    got = 0;
    req_valid = start;
    for (int k = 0; k < 2000 && got < n; k++) begin
      tick;
      got += $countones(req_grant);
      req_valid = req_valid & ~req_grant;
      if (reassert) req_valid = req_valid | req_done;
    end
    req_valid = '0;
    chk("rr_grant_count", 32'(got), 32'(n));
    for (int k = 0; k < 300 && busy; k++) tick;
    chk("rr_idle_after", 32'(busy), 32'd0);
  endtask

  int n0, g0, d0, p0;
  int exp_a[5], exp_d[5];
  int exp_rr[5];

  initial begin
    n_chk = 0; n_err = 0;
    RESET = 1'b1; req_valid = '0; stale_int = 1'b0; int_delay = 0;
    req_rd_addr = '0; req_wr_addr = '0; req_len = '0; req_rd_inc = '0; req_wr_inc = '0;
    #1;
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_psel",    32'(apb.M_PSEL), 32'd0);
    chk("rst_pclken",  32'(apb.M_PCLKEN), 32'd1);
    chk("rst_grant",   32'(req_grant), 32'd0);
    chk("rst_done",    32'(req_done), 32'd0);
    chk("rst_cur",     32'(cur_chan), 32'd0);
    do_reset;

    // Single job on requester 0
    int_delay = 20;
    set_job(0, 32'h2000_0000, 32'h2000_1000, 32'd8, 1'b1, 1'b1);
    n0 = wa.size(); g0 = g_idx.size(); d0 = d_idx.size(); p0 = psel_cnt;
    run_one(0, 200, 1 << 30);
    exp_a = '{'h000, 'h004, 'h008, 'h00C, 'h00C};
    exp_d = '{'h2000_0000, 'h2000_1000, 8, 'h1B, 'h1E};
    chk("single_nwr", 32'(wa.size() - n0), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (n0 + k < wa.size()) begin
        chk($sformatf("single_addr%0d", k), 32'(wa[n0+k]), 32'(exp_a[k]));
        chk($sformatf("single_data%0d", k), 32'(wd[n0+k]), 32'(exp_d[k]));
      end
    end
    if (wa.size() >= n0 + 5 && g_idx.size() > g0 && d_idx.size() > d0) begin
      chk("single_prog_span", 32'(wc[n0+3] - wc[n0]), 32'd6);
      chk("single_first_wr",  32'(wc[n0] - g_cyc[g0]), 32'd1);
      chk("single_int_lat",   32'(wc[n0+4] - wc[n0+3]), 32'd22);
      chk("single_done_idx",  32'(d_idx[d0]), 32'd0);
      chk("single_done_err",  32'(d_err[d0]), 32'd0);
    end
    chk("single_psel_cyc", 32'(psel_cnt - p0), 32'd10);

    // All four requesting, re-raised after each done
    do_reset;
    int_delay = 5;
    for (int i = 0; i < 4; i++) set_job(i, 32'(i) << 8, 32'h1000 + (32'(i) << 8), 32'd4, 1'b1, 1'b1);
    g0 = g_idx.size();
    rr_run(4'b1111, 1'b1, 5);
    exp_rr = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++)
      if (g0 + k < g_idx.size()) chk($sformatf("rr_order%0d", k), 32'(g_idx[g0+k]), 32'(exp_rr[k]));

    // Pointer moved to 2 by a zero-length job on req 1, then 0 and 1 compete
    do_reset;
    set_job(1, 32'h0, 32'h0, 32'd0, 1'b0, 1'b0);
    run_one(1, 20, 1 << 30);
    set_job(0, 32'h10, 32'h20, 32'd4, 1'b1, 1'b1);
    set_job(1, 32'h30, 32'h40, 32'd4, 1'b1, 1'b1);
    g0 = g_idx.size();
    rr_run(4'b0011, 1'b0, 2);
    if (g_idx.size() >= g0 + 2) begin
      chk("wrap_first",  32'(g_idx[g0]), 32'd0);
      chk("wrap_second", 32'(g_idx[g0+1]), 32'd1);
    end

    // Zero length on req 3
    do_reset;
    set_job(3, 32'h5000, 32'h6000, 32'd0, 1'b1, 1'b1);
    g0 = g_idx.size(); d0 = d_idx.size(); p0 = psel_cnt;
    run_one(3, 20, 1 << 30);
    chk("zero_psel", 32'(psel_cnt - p0), 32'd0);
    if (d_idx.size() > d0 && g_idx.size() > g0) begin
      chk("zero_done_idx", 32'(d_idx[d0]), 32'd3);
      chk("zero_done_err", 32'(d_err[d0]), 32'd1);
      chk("zero_done_lat", 32'(d_cyc[d0] - g_cyc[g0]), 32'd1);
    end

    // Timeout: interrupt never raised
    do_reset;
    int_delay = 0;
    set_job(2, 32'h100, 32'h200, 32'd16, 1'b1, 1'b0);
    n0 = wa.size(); d0 = d_idx.size();
    run_one(2, 400, 1 << 30);
    chk("tmo_nwr", 32'(wa.size() - n0), 32'd5);
    if (wa.size() >= n0 + 5) begin
      chk("tmo_ctrl_data", 32'(wd[n0+3]), 32'h0B);
      chk("tmo_clr_gap",   32'(wc[n0+4] - wc[n0+3]), 32'd102);
      chk("tmo_clr_data",  32'(wd[n0+4]), 32'h0E);
    end
    if (d_idx.size() > d0) begin
      chk("tmo_done_idx", 32'(d_idx[d0]), 32'd2);
      chk("tmo_done_err", 32'(d_err[d0]), 32'd1);
    end

    // Stale interrupt at capture
    do_reset;
    int_delay = 20;
    set_job(0, 32'hA0, 32'hB0, 32'd2, 1'b0, 1'b0);
    n0 = wa.size(); d0 = d_idx.size();
    stale_int = 1'b1;
    run_one(0, 300, n0);
    chk("stale_nwr", 32'(wa.size() - n0), 32'd6);
    if (wa.size() >= n0 + 6) begin
      chk("stale_pre_addr", 32'(wa[n0]), 32'h00C);
      chk("stale_pre_data", 32'(wd[n0]), 32'h006);
      chk("stale_rd_addr",  32'(wa[n0+1]), 32'h000);
      chk("stale_ctrl",     32'(wd[n0+4]), 32'h003);
    end
    if (d_idx.size() > d0) chk("stale_done_err", 32'(d_err[d0]), 32'd0);

    // Reset in the middle of programming
    do_reset;
    int_delay = 20;
    set_job(0, 32'h2000_0000, 32'h2000_1000, 32'd8, 1'b1, 1'b1);
    d0 = d_idx.size();
    req_valid[0] = 1'b1;
    for (int k = 0; k < 20 && !req_grant[0]; k++) tick;
    req_valid[0] = 1'b0;
    repeat (2) tick;
    chk("mid_psel_before",  32'(apb.M_PSEL), 32'd1);
    chk("mid_paddr_before", 32'(apb.M_PADDR), 32'h004);
    RESET = 1'b1;
    #1;
    chk("mid_psel",    32'(apb.M_PSEL), 32'd0);
    chk("mid_penable", 32'(apb.M_PENABLE), 32'd0);
    chk("mid_pwrite",  32'(apb.M_PWRITE), 32'd0);
    chk("mid_paddr",   32'(apb.M_PADDR), 32'd0);
    chk("mid_pwdata",  apb.M_PWDATA, 32'd0);
    chk("mid_busy",    32'(busy), 32'd0);
    chk("mid_pclken",  32'(apb.M_PCLKEN), 32'd1);
    tick;
    RESET = 1'b0;
    repeat (40) tick;
    chk("mid_no_done", 32'(d_idx.size() - d0), 32'd0);
    chk("mid_idle",    32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/dma_cxy_job_sched.md
Name: dma_cxy_job_sched

Overview:
- Multi-requester job scheduler for the custom AHB DMA engine.
- Accepts copy jobs from N requesters and arbitrates between them round-robin.
- For each job, programs the DMA through its APB register window (rd_addr 0x000, wr_addr 0x004, trans_len 0x008, ctrl 0x00C), waits for the DMA interrupt, clears it, and reports done or error to the owning requester.
- Sits between the peripheral masters and the DMA's APB slave port, and is the only APB master of the DMA.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 65536, cycles to wait for the interrupt before flagging an error; 0 disables the timeout.

Ports:
- FCLK in 1: clock.
- RESET in 1: asynchronous, active-high reset.
- req_valid in N_REQ: job pending, one bit per requester; held until that requester's req_grant.
- req_rd_addr in N_REQ*32: source address, requester i at bits [32i+31:32i].
- req_wr_addr in N_REQ*32: destination address, same packing.
- req_len in N_REQ*32: transfer length in words, same packing.
- req_rd_inc in N_REQ: source address increment enable.
- req_wr_inc in N_REQ: destination address increment enable.
- req_grant out N_REQ: one-cycle pulse, job captured.
- req_done out N_REQ: one-cycle pulse, job finished.
- req_err out N_REQ: valid with req_done; 1 = zero length or timeout.
- busy out 1: a job is held (scheduler not in IDLE).
- cur_chan out 3: index of the captured job.
- M_PCLKEN out 1: constant 1.
- M_PSEL out 1: APB select to the DMA.
- M_PENABLE out 1: APB enable to the DMA.
- M_PWRITE out 1: APB write strobe.
- M_PADDR out 12: APB address.
- M_PWDATA out 32: APB write data.
- dma_int in 1: DMA_CXY_INT from the DMA.

Behaviour:
- Reset values: all outputs 0 except M_PCLKEN=1; state IDLE; RR pointer 0; timeout counter 0.
- RESET mid-job abandons the job with no done pulse. The system must also reset the DMA.
- Arbitration:
  - In IDLE with any req_valid, pick the first set bit at or after the pointer, wrapping at N_REQ.
  - Capture that job's fields and set the pointer to winner+1 mod N_REQ.
  - req_grant[winner]=1 in the following cycle.
  - Other requests wait; no preemption.
- Zero length (captured len==0): no APB traffic. Go to DONE, where req_done and req_err pulse for the winner.
- APB write protocol, 2 cycles per write, no wait states:
  - SETUP cycle: PSEL=1, PENABLE=0, PWRITE=1, PADDR and PWDATA valid.
  - ACCESS cycle: PENABLE=1.
  - All bus signals return to 0 afterwards. PSEL is never held across writes.
- States:
  - IDLE: arbitrate as above.
  - PRECLR: entered from IDLE only if dma_int=1 at capture (stale interrupt). Perform the clear write, then wait for dma_int=0, then go to PROG.
  - PROG: four back-to-back writes, 8 cycles total, in order:
    - 0x000 = rd_addr
    - 0x004 = wr_addr
    - 0x008 = len
    - 0x00C = 0x3 | rd_inc<<3 | wr_inc<<4 (start, int_en)
  - WAIT_INT:
    - Counter increments each cycle.
    - dma_int=1 goes to CLR with err=0.
    - Counter reaching TIMEOUT_CYC (when nonzero) goes to CLR with err=1.
  - CLR: write 0x00C = 0x6 | rd_inc<<3 | wr_inc<<4 (int_clr, int_en, no start).
  - WAIT_LOW: wait until dma_int=0, then go to DONE. dma_int stays low on timeout, so this passes immediately.
  - DONE: req_done[cur]=1 and req_err[cur]=err for one cycle, then IDLE.
- Arbitration resumes the cycle after DONE. Minimum job-to-job gap is 1 idle cycle.
- Simultaneous events:
  - dma_int and timeout in the same cycle: dma_int wins (err=0).
  - A new req_valid during a job is ignored until IDLE.
- busy=1 in every state except IDLE.

Decomposition:
- Package dma_cxy_pkg holds:
  - register offsets (DMA_REG_RD/WR/LEN/CTRL);
  - ctrl bit positions (start 0, int_en 1, int_clr 2, rd_inc 3, wr_inc 4, int_status 5);
  - the state enum;
  - the APB phase enum.
- One sub-module, dma_cxy_rr_arb: round-robin pick from valid bits and pointer, giving a one-hot winner and an index.

Test Plan:
- Single job (req 0: rd=0x2000_0000, wr=0x2000_1000, len=8, both inc=1) -> 8 APB cycles: 0x000=0x2000_0000, 0x004=0x2000_1000, 0x008=8, 0x00C=0x1B. DMA model raises int after 20 cycles -> clear write 0x00C=0x1E -> req_done[0]=1, req_err[0]=0.
- req_valid=4'b1111 held, re-asserted after each done -> grant order 0,1,2,3,0.
- Pointer at 2 with req_valid=4'b0011 -> grant 0 then 1 (wrap).
- len=0 on req 3 -> no PSEL activity; req_done[3] and req_err[3] both pulse 2 cycles after capture.
- TIMEOUT_CYC=100 with int never raised -> clear write issued after 100 cycles; req_err=1.
- dma_int held high at capture -> PRECLR clear write precedes 0x000 write. RESET asserted during PROG -> all M_P* signals 0 immediately, state IDLE, no done pulse.
